// File: rtl/dmem_stage.sv
// MEM-stage data RAM with a fixed multi-cycle access latency and pipeline stall.
// Defining DMEM_MISALIGN_TRAP_EN adds misalign_o and refuses non-word-aligned accesses.
module dmem_stage #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        busy_o
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int         DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] idx_q;
    logic [31:0]          wdata_q;
    logic                 wr_q;
    logic [31:0]          mem [DEPTH];

    logic req;
    logic bad_align;
    logic accept;
    logic commit;
    logic unused_addr;

    assign req = M_i[1] | M_i[0];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad_align  = (state == IDLE) && req && (addr_i[1:0] != 2'b00);
    assign misalign_o = bad_align;
`else
    assign bad_align  = 1'b0;
`endif

    // Upper address bits alias; byte offset only matters with the trap enabled.
    assign unused_addr = ^{addr_i[31:ADDR_BITS+2], addr_i[1:0]};

    assign accept  = (state == IDLE) && req && !bad_align;
    assign commit  = (state == BUSY) && (cnt == 4'd0);
    assign stall_o = accept || (state == BUSY);
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                        if (!wr_q) rdata_o <= mem[idx_q];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields are captured once, at acceptance, and held through BUSY.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_q   <= addr_i[ADDR_BITS+1:2];
            wdata_q <= wdata_i;
            wr_q    <= M_i[0];
        end
    end

    // Array is never reset; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q && !rst_i) mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboard bench for dmem_stage: LATENCY=2 main instance plus LATENCY=1/15 instances for stall length.
module tb_dmem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m0, m1, m15;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata1_unused, rdata15_unused;
    logic        stall0, busy0, stall1, busy1, stall15, busy15;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        mis0, mis1_unused, mis15_unused;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [256];
    logic [31:0] model_rdata;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_stage #(.ADDR_BITS(8), .LATENCY(2)) dut0 (
        .clk_i(clk), .rst_i(rst), .M_i(m0), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata0), .stall_o(stall0), .busy_o(busy0)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .misalign_o(mis0)
`endif
    );

    dmem_stage #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .M_i(m1), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata1_unused), .stall_o(stall1), .busy_o(busy1)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .misalign_o(mis1_unused)
`endif
    );

    dmem_stage #(.ADDR_BITS(8), .LATENCY(15)) dut15 (
        .clk_i(clk), .rst_i(rst), .M_i(m15), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata15_unused), .stall_o(stall15), .busy_o(busy15)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .misalign_o(mis15_unused)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE edge with M cleared.
    task automatic mem_access(input logic [1:0] m, input logic [31:0] a,
                              input logic [31:0] d, input string tag);
        int          stalls = 0;
        int          busys  = 0;
        int          n      = 0;
        bit          done   = 1'b0;
        logic [31:0] expv;
        m0 = m; addr = a; wdata = d;
        if (m == 2'b10) model_rdata = model[a[9:2]];
        else model[a[9:2]] = d;
        exp_q.push_back(model_rdata);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (stall0) stalls++;
            if (busy0) busys++;
            if (busy0 && !stall0) begin
                done = 1'b1;
                expv = exp_q.pop_front();
                check({tag, "_rdata"}, rdata0, expv);
            end
            @(posedge clk); #1;
        end
        m0 = 2'b00;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_stall_len"}, stalls, 32'd3);
        check({tag, "_busy_len"}, busys, 32'd3);
    endtask

    task automatic sweep(input int lat);
        int   stalls = 0;
        int   n      = 0;
        bit   done   = 1'b0;
        logic s, b;
        addr = 32'h44; wdata = 32'h0000_0077;
        if (lat == 1) m1 = 2'b01;
        else m15 = 2'b01;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            s = (lat == 1) ? stall1 : stall15;
            b = (lat == 1) ? busy1 : busy15;
            if (s) stalls++;
            if (b && !s) done = 1'b1;
            @(posedge clk); #1;
        end
        m1 = 2'b00; m15 = 2'b00;
        check($sformatf("lat%0d_done", lat), {31'd0, done}, 32'd1);
        check($sformatf("lat%0d_stall_len", lat), stalls, lat + 1);
    endtask

    initial begin
        rst = 1'b1; m0 = 2'b00; m1 = 2'b00; m15 = 2'b00;
        addr = 32'd0; wdata = 32'd0; model_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_stall", {31'd0, stall0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        @(posedge clk); #1;

        mem_access(2'b01, 32'h10, 32'hDEADBEEF, "wr10");
        mem_access(2'b10, 32'h10, 32'h0, "rd10");

        // Abort a write with reset on the edge where it would commit.
        mem_access(2'b01, 32'h20, 32'h0, "wr20_zero");
        m0 = 2'b01; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_in_busy", {31'd0, busy0}, 32'd1);
        check("abort_stall", {31'd0, stall0}, 32'd1);
        rst = 1'b1; m0 = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rdata = 32'd0;
        @(negedge clk);
        check("abort_rdata", rdata0, 32'd0);
        check("abort_stall_after", {31'd0, stall0}, 32'd0);
        check("abort_busy_after", {31'd0, busy0}, 32'd0);
        @(posedge clk); #1;
        mem_access(2'b10, 32'h20, 32'h0, "rd20");

        mem_access(2'b01, 32'h400, 32'hCAFEF00D, "wr400");
        mem_access(2'b10, 32'h000, 32'h0, "rd000_alias");

        mem_access(2'b01, 32'h40, 32'h11111111, "wr40");
        mem_access(2'b10, 32'h40, 32'h0, "rd40");
        mem_access(2'b11, 32'h30, 32'h55AA55AA, "both30");
        mem_access(2'b10, 32'h30, 32'h0, "rd30");

        m0 = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d_stall", i), {31'd0, stall0}, 32'd0);
            check($sformatf("idle%0d_busy", i), {31'd0, busy0}, 32'd0);
            check($sformatf("idle%0d_rdata", i), rdata0, model_rdata);
            @(posedge clk); #1;
        end

        sweep(1);
        sweep(15);

`ifdef DMEM_MISALIGN_TRAP_EN
        m0 = 2'b10; addr = 32'h13;
        @(negedge clk);
        check("mis_flag", {31'd0, mis0}, 32'd1);
        check("mis_stall", {31'd0, stall0}, 32'd0);
        check("mis_busy", {31'd0, busy0}, 32'd0);
        @(posedge clk); #1;
        m0 = 2'b00;
        @(negedge clk);
        check("mis_idle_busy", {31'd0, busy0}, 32'd0);
        check("mis_rdata", rdata0, model_rdata);
        check("mis_clear", {31'd0, mis0}, 32'd0);
        @(posedge clk); #1;
`else
        mem_access(2'b10, 32'h13, 32'h0, "rd13");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
